// File: rtl/up_axi_initiator_pkg.sv
// Shared constants and types for the AXI4-Lite to up-bus initiator.
package up_axi_initiator_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   // Width of the shared timeout counter; covers TIMEOUT_CYCLES up to 65535.
   localparam int unsigned TIMEOUT_CNT_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_WAIT = 3'd2,
      ST_WR_RESP = 3'd3,
      ST_RD_REQ  = 3'd4,
      ST_RD_WAIT = 3'd5,
      ST_RD_RESP = 3'd6
   } state_t;

   typedef enum logic {
      GRANT_WRITE = 1'b0,
      GRANT_READ  = 1'b1
   } grant_t;

endpackage

// File: rtl/up_axi_initiator_if.sv
// AXI4-Lite slave channel plus up register bus, bundled for the initiator.
interface up_axi_initiator_if #(
   parameter int unsigned AXI_ADDRESS_WIDTH = 16
) ();

   logic                         awvalid;
   logic                         awready;
   logic [AXI_ADDRESS_WIDTH-1:0] awaddr;
   logic                         wvalid;
   logic                         wready;
   logic [31:0]                  wdata;
   logic [3:0]                   wstrb;
   logic                         bvalid;
   logic                         bready;
   logic [1:0]                   bresp;
   logic                         arvalid;
   logic                         arready;
   logic [AXI_ADDRESS_WIDTH-1:0] araddr;
   logic                         rvalid;
   logic                         rready;
   logic [31:0]                  rdata;
   logic [1:0]                   rresp;

   logic                         up_wreq;
   logic [AXI_ADDRESS_WIDTH-3:0] up_waddr;
   logic [31:0]                  up_wdata;
   logic                         up_wack;
   logic                         up_rreq;
   logic [AXI_ADDRESS_WIDTH-3:0] up_raddr;
   logic [31:0]                  up_rdata;
   logic                         up_rack;

   // Initiator side: AXI slave port, up bus request driver.
   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  up_wack, up_rack, up_rdata,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
      output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
   );

   // AXI master / up responder side.
   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output up_wack, up_rack, up_rdata,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
      input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
   );

endinterface

// File: rtl/up_axi_timeout_cnt.sv
// Loadable saturating up-counter with terminal-count flag for ack timeouts.
module up_axi_timeout_cnt
   import up_axi_initiator_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expired
);

   localparam logic [TIMEOUT_CNT_WIDTH-1:0] TERMINAL = TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_CNT_WIDTH-1:0] cnt;

   // Load with 1 in the request cycle so the value equals cycles elapsed since the
   // request pulse; saturate so the count never wraps back through TERMINAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= TIMEOUT_CNT_WIDTH'(1);
      end else if (cnt != '1) begin
         cnt <= cnt + TIMEOUT_CNT_WIDTH'(1);
      end
   end

   assign expired = (cnt == TERMINAL);

endmodule

// File: rtl/up_axi_initiator.sv
// AXI4-Lite slave to up register bus initiator: one outstanding transaction,
// round-robin read/write arbitration, timeout-backed responses.
module up_axi_initiator
   import up_axi_initiator_pkg::*;
#(
   parameter int unsigned AXI_ADDRESS_WIDTH = 16,
   parameter int unsigned TIMEOUT_CYCLES    = 255,
   parameter logic [31:0] TIMEOUT_RDATA     = 32'hDEADDEAD
) (
   input  logic                 up_clk,
   input  logic                 up_rstn,
   up_axi_initiator_if.slave    bus
);

   localparam int unsigned UAW = AXI_ADDRESS_WIDTH - 2;

   state_t          state, state_n;
   grant_t          last_grant, last_grant_n;
   logic            armed;
   logic [UAW-1:0]  waddr_q, waddr_n, raddr_q, raddr_n;
   logic [31:0]     wdata_q, wdata_n, rdata_q, rdata_n;
   logic [3:0]      wstrb_q, wstrb_n;
   logic [1:0]      bresp_q, bresp_n, rresp_q, rresp_n;
   logic            aw_grant, ar_grant, cnt_load, expired;
   logic            wr_pending, rd_pending, strb_full;

   assign wr_pending = bus.awvalid && bus.wvalid;
   assign rd_pending = bus.arvalid;
   assign strb_full  = (wstrb_q == 4'hF);

   up_axi_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (up_clk),
      .rst_n   (up_rstn),
      .load    (cnt_load),
      .expired (expired)
   );

   // State, arbitration history and latched transaction fields.
   // armed keeps the combinational readies low while reset is held.
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         state      <= ST_IDLE;
         last_grant <= GRANT_READ;
         armed      <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         raddr_q    <= '0;
         bresp_q    <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
      end else begin
         state      <= state_n;
         last_grant <= last_grant_n;
         armed      <= 1'b1;
         waddr_q    <= waddr_n;
         wdata_q    <= wdata_n;
         wstrb_q    <= wstrb_n;
         raddr_q    <= raddr_n;
         bresp_q    <= bresp_n;
         rdata_q    <= rdata_n;
         rresp_q    <= rresp_n;
      end
   end

   // Next-state, grant and response capture decisions.
   always_comb begin
      state_n      = state;
      last_grant_n = last_grant;
      waddr_n      = waddr_q;
      wdata_n      = wdata_q;
      wstrb_n      = wstrb_q;
      raddr_n      = raddr_q;
      bresp_n      = bresp_q;
      rdata_n      = rdata_q;
      rresp_n      = rresp_q;
      aw_grant     = 1'b0;
      ar_grant     = 1'b0;
      cnt_load     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (armed) begin
               if (wr_pending && (!rd_pending || last_grant == GRANT_READ)) begin
                  aw_grant = 1'b1;
                  waddr_n  = bus.awaddr[AXI_ADDRESS_WIDTH-1:2];
                  wdata_n  = bus.wdata;
                  wstrb_n  = bus.wstrb;
                  state_n  = ST_WR_REQ;
               end else if (rd_pending) begin
                  ar_grant = 1'b1;
                  raddr_n  = bus.araddr[AXI_ADDRESS_WIDTH-1:2];
                  state_n  = ST_RD_REQ;
               end
            end
         end
         ST_WR_REQ: begin
            if (!strb_full) begin
               bresp_n = AXI_RESP_SLVERR;
               state_n = ST_WR_RESP;
            end else begin
               cnt_load = 1'b1;
               state_n  = ST_WR_WAIT;
            end
         end
         ST_WR_WAIT: begin
            if (bus.up_wack) begin
               bresp_n = AXI_RESP_OKAY;
               state_n = ST_WR_RESP;
            end else if (expired) begin
               bresp_n = AXI_RESP_SLVERR;
               state_n = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (bus.bready) begin
               last_grant_n = GRANT_WRITE;
               state_n      = ST_IDLE;
            end
         end
         ST_RD_REQ: begin
            cnt_load = 1'b1;
            state_n  = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (bus.up_rack) begin
               rdata_n = bus.up_rdata;
               rresp_n = AXI_RESP_OKAY;
               state_n = ST_RD_RESP;
            end else if (expired) begin
               rdata_n = TIMEOUT_RDATA;
               rresp_n = AXI_RESP_SLVERR;
               state_n = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            if (bus.rready) begin
               last_grant_n = GRANT_READ;
               state_n      = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign bus.awready  = aw_grant;
   assign bus.wready   = aw_grant;
   assign bus.arready  = ar_grant;
   assign bus.bvalid   = (state == ST_WR_RESP);
   assign bus.bresp    = bresp_q;
   assign bus.rvalid   = (state == ST_RD_RESP);
   assign bus.rdata    = rdata_q;
   assign bus.rresp    = rresp_q;
   assign bus.up_wreq  = (state == ST_WR_REQ) && strb_full;
   assign bus.up_waddr = waddr_q;
   assign bus.up_wdata = wdata_q;
   assign bus.up_rreq  = (state == ST_RD_REQ);
   assign bus.up_raddr = raddr_q;

endmodule

// File: tb/tb_up_axi_initiator.sv
// Self-checking bench for up_axi_initiator: transaction-level model plus directed tests.
module tb_up_axi_initiator;

   localparam int unsigned TC = 16;

   logic up_clk  = 1'b0;
   logic up_rstn = 1'b0;

   up_axi_initiator_if #(.AXI_ADDRESS_WIDTH(16)) bus ();

   up_axi_initiator #(
      .AXI_ADDRESS_WIDTH (16),
      .TIMEOUT_CYCLES    (TC),
      .TIMEOUT_RDATA     (32'hDEADDEAD)
   ) dut (
      .up_clk  (up_clk),
      .up_rstn (up_rstn),
      .bus     (bus)
   );

   always #5 up_clk = ~up_clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge up_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Responder configuration (0 = never acks).
   int unsigned wdelay    = 0;
   int unsigned rdelay    = 0;
   logic [31:0] rsp_rdata = '0;

   // Responder: ack a fixed number of cycles after each request pulse.
   initial begin : responder
      int unsigned wc;
      int unsigned rc;
      wc = 0;
      rc = 0;
      bus.up_wack  = 1'b0;
      bus.up_rack  = 1'b0;
      bus.up_rdata = '0;
      forever begin
         @(posedge up_clk);
         #1;
         bus.up_wack  = 1'b0;
         bus.up_rack  = 1'b0;
         bus.up_rdata = '0;
         if (!up_rstn) begin
            wc = 0;
            rc = 0;
         end else begin
            if (wc > 0) begin
               wc--;
               if (wc == 0) bus.up_wack = 1'b1;
            end
            if (rc > 0) begin
               rc--;
               if (rc == 0) begin
                  bus.up_rack  = 1'b1;
                  bus.up_rdata = rsp_rdata;
               end
            end
            if (bus.up_wreq) wc = wdelay;
            if (bus.up_rreq) rc = rdelay;
         end
      end
   end

   // Transaction model state.
   bit          m_busy = 1'b0;
   bit          m_last = 1'b1;     // 1 = read was last served
   bit          m_kind = 1'b0;     // 1 = read
   bit          m_okay = 1'b0;
   int          m_g = 0, m_v = 0, m_ready_cyc = 0;
   logic [13:0] m_addr = '0;
   logic [31:0] m_wdata = '0, m_rdata = '0;
   logic [3:0]  m_strb = '0;
   bit          grant_log[$];
   int          n_wreq = 0, n_rreq = 0, n_resp = 0;
   int          last_rreq_cyc = 0, last_rv_cyc = 0;
   logic [13:0] last_waddr = '0, last_raddr = '0;
   logic [31:0] last_wdata = '0;
   bit          prev_rv = 1'b0;

   // Compare process: every cycle out of reset, DUT outputs against the model.
   always @(negedge up_clk) begin : compare
      bit wpend, rpend, ew, er, ewq, erq, eb, erv;
      if (!up_rstn) begin
         m_busy      = 1'b0;
         m_last      = 1'b1;
         m_ready_cyc = cyc + 2;
         prev_rv     = 1'b0;
      end else begin
         wpend = bus.awvalid && bus.wvalid;
         rpend = bus.arvalid;
         if (m_busy || cyc >= m_ready_cyc) begin
            ew = !m_busy && wpend && (!rpend || m_last);
            er = !m_busy && rpend && !ew;
            chk("awready", bus.awready, ew);
            chk("wready", bus.wready, ew);
            chk("arready", bus.arready, er);
            if (ew || er) begin
               m_busy = 1'b1;
               m_kind = er;
               m_g    = cyc;
               grant_log.push_back(er);
            end
            if (ew) begin
               m_addr  = bus.awaddr[15:2];
               m_wdata = bus.wdata;
               m_strb  = bus.wstrb;
               m_okay  = (bus.wstrb == 4'hF) && (wdelay > 0) && (wdelay < TC);
               if (bus.wstrb != 4'hF) m_v = cyc + 2;
               else if (m_okay)       m_v = cyc + 2 + int'(wdelay);
               else                   m_v = cyc + 1 + int'(TC);
            end else if (er) begin
               m_addr  = bus.araddr[15:2];
               m_okay  = (rdelay > 0) && (rdelay < TC);
               m_rdata = m_okay ? rsp_rdata : 32'hDEADDEAD;
               m_v     = m_okay ? cyc + 2 + int'(rdelay) : cyc + 1 + int'(TC);
            end
         end
         ewq = m_busy && !m_kind && (m_strb == 4'hF) && (cyc == m_g + 1);
         erq = m_busy && m_kind && (cyc == m_g + 1);
         chk("up_wreq", bus.up_wreq, ewq);
         chk("up_rreq", bus.up_rreq, erq);
         if (bus.up_wreq) begin
            n_wreq++;
            last_waddr = bus.up_waddr;
            last_wdata = bus.up_wdata;
            if (ewq) begin
               chk("up_waddr", bus.up_waddr, m_addr);
               chk("up_wdata", bus.up_wdata, m_wdata);
            end
         end
         if (bus.up_rreq) begin
            n_rreq++;
            last_rreq_cyc = cyc;
            last_raddr    = bus.up_raddr;
            if (erq) chk("up_raddr", bus.up_raddr, m_addr);
         end
         eb  = m_busy && !m_kind && (cyc >= m_v);
         erv = m_busy && m_kind && (cyc >= m_v);
         chk("bvalid", bus.bvalid, eb);
         chk("rvalid", bus.rvalid, erv);
         if (eb) chk("bresp", bus.bresp, m_okay ? 2'b00 : 2'b10);
         if (erv) begin
            chk("rdata", bus.rdata, m_rdata);
            chk("rresp", bus.rresp, m_okay ? 2'b00 : 2'b10);
         end
         if (bus.rvalid && !prev_rv) last_rv_cyc = cyc;
         prev_rv = bus.rvalid;
         if ((eb && bus.bready) || (erv && bus.rready)) begin
            m_busy      = 1'b0;
            m_last      = m_kind;
            m_ready_cyc = cyc + 1;
            n_resp++;
         end
      end
   end

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int unsigned hold, output logic [1:0] resp);
      int unsigned n;
      @(posedge up_clk); #1;
      bus.awvalid = 1'b1; bus.awaddr = a;
      bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
      n = 0;
      @(negedge up_clk);
      while (!bus.awready && n < 100) begin @(negedge up_clk); n++; end
      chk("aw_accept_bound", n < 100, 1'b1);
      @(posedge up_clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      n = 0;
      @(negedge up_clk);
      while (!bus.bvalid && n < 200) begin @(negedge up_clk); n++; end
      chk("b_valid_bound", n < 200, 1'b1);
      resp = bus.bresp;
      repeat (hold + 1) @(posedge up_clk);
      #1 bus.bready = 1'b1;
      @(posedge up_clk); #1 bus.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [15:0] a, input int unsigned hold,
                           output logic [31:0] data, output logic [1:0] resp);
      int unsigned n;
      @(posedge up_clk); #1;
      bus.arvalid = 1'b1; bus.araddr = a;
      n = 0;
      @(negedge up_clk);
      while (!bus.arready && n < 100) begin @(negedge up_clk); n++; end
      chk("ar_accept_bound", n < 100, 1'b1);
      @(posedge up_clk); #1 bus.arvalid = 1'b0;
      n = 0;
      @(negedge up_clk);
      while (!bus.rvalid && n < 200) begin @(negedge up_clk); n++; end
      chk("r_valid_bound", n < 200, 1'b1);
      data = bus.rdata;
      resp = bus.rresp;
      repeat (hold + 1) @(posedge up_clk);
      #1 bus.rready = 1'b1;
      @(posedge up_clk); #1 bus.rready = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                           bus.up_wreq, bus.up_rreq}, '0);
      chk({tag, "_resp"}, {bus.bresp, bus.rresp}, '0);
      chk({tag, "_waddr"}, bus.up_waddr, '0);
      chk({tag, "_raddr"}, bus.up_raddr, '0);
      chk({tag, "_wdata"}, bus.up_wdata, '0);
      chk({tag, "_rdata"}, bus.rdata, '0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog simulation did not complete actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [1:0]  resp;
      logic [31:0] data;
      int          base_w, base_r, base_g, base_resp;
      int unsigned n;

      bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.bready  = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;

      // Reset: outputs stay zero even with requests pending.
      repeat (3) @(posedge up_clk);
      #1;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.wstrb = 4'hF; bus.arvalid = 1'b1;
      #2 chk_all_zero("reset");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      @(posedge up_clk); #2 up_rstn = 1'b1;
      repeat (3) @(posedge up_clk);

      // Write acked 3 cycles after up_wreq.
      wdelay = 3;
      base_w = n_wreq;
      axi_write(16'h0044, 32'h12345678, 4'hF, 0, resp);
      chk("t1_bresp", resp, 2'b00);
      chk("t1_waddr", last_waddr, 14'h0011);
      chk("t1_wdata", last_wdata, 32'h12345678);
      chk("t1_wreq_count", n_wreq - base_w, 1);

      // Partial strobe: rejected without touching the up bus.
      base_w = n_wreq;
      axi_write(16'h0048, 32'h87654321, 4'h3, 0, resp);
      chk("t4_bresp", resp, 2'b10);
      chk("t4_wreq_count", n_wreq - base_w, 0);

      // Read with ack; R channel back-pressured for 5 cycles.
      rdelay = 2; rsp_rdata = 32'hCAFEF00D;
      axi_read(16'h4000, 5, data, resp);
      chk("t2_rdata", data, 32'hCAFEF00D);
      chk("t2_rresp", resp, 2'b00);
      chk("t2_raddr", last_raddr, 14'h1000);

      // Read timeout with a late ack 20 cycles after up_rreq.
      rdelay = 20; rsp_rdata = 32'h11112222;
      axi_read(16'h0080, 8, data, resp);
      chk("t3_rdata", data, 32'hDEADDEAD);
      chk("t3_rresp", resp, 2'b10);
      chk("t3_latency", last_rv_cyc - last_rreq_cyc, 16);

      // Contested arbitration: AW+W and AR held together for 4 transactions.
      wdelay = 1; rdelay = 1; rsp_rdata = 32'h0BADBEEF;
      base_w = n_wreq; base_r = n_rreq; base_g = grant_log.size(); base_resp = n_resp;
      @(posedge up_clk); #1;
      bus.bready = 1'b1; bus.rready = 1'b1;
      bus.awvalid = 1'b1; bus.awaddr = 16'h0008; bus.wvalid = 1'b1; bus.wdata = 32'hA5A50001;
      bus.wstrb = 4'hF; bus.arvalid = 1'b1; bus.araddr = 16'h000C;
      n = 0;
      while (grant_log.size() < base_g + 4 && n < 300) begin @(posedge up_clk); n++; end
      chk("t5_grant_bound", n < 300, 1'b1);
      #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      n = 0;
      while (n_resp < base_resp + 4 && n < 300) begin @(posedge up_clk); n++; end
      chk("t5_resp_bound", n < 300, 1'b1);
      #1 bus.bready = 1'b0; bus.rready = 1'b0;
      chk("t5_grant_count", grant_log.size() - base_g, 4);
      if (grant_log.size() >= base_g + 4) begin
         chk("t5_grant0", grant_log[base_g + 0], 1'b0);
         chk("t5_grant1", grant_log[base_g + 1], 1'b1);
         chk("t5_grant2", grant_log[base_g + 2], 1'b0);
         chk("t5_grant3", grant_log[base_g + 3], 1'b1);
      end
      chk("t5_wreq_count", n_wreq - base_w, 2);
      chk("t5_rreq_count", n_rreq - base_r, 2);

      // Reset while waiting for a write ack that never comes.
      wdelay = 0;
      repeat (2) @(posedge up_clk);
      #1;
      bus.awvalid = 1'b1; bus.awaddr = 16'h0100; bus.wvalid = 1'b1; bus.wdata = 32'h00000055;
      bus.wstrb = 4'hF;
      base_w = n_wreq;
      n = 0;
      @(negedge up_clk);
      while (!bus.awready && n < 100) begin @(negedge up_clk); n++; end
      chk("t6_aw_bound", n < 100, 1'b1);
      @(posedge up_clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      n = 0;
      while (n_wreq == base_w && n < 100) begin @(posedge up_clk); n++; end
      chk("t6_wreq_bound", n < 100, 1'b1);
      repeat (3) @(posedge up_clk);
      #3 up_rstn = 1'b0;
      #1 chk_all_zero("midrst");
      repeat (2) @(posedge up_clk);
      #2 up_rstn = 1'b1;
      repeat (3) @(posedge up_clk);
      rdelay = 2; rsp_rdata = 32'h600DF00D;
      axi_read(16'h0020, 0, data, resp);
      chk("t6_rdata", data, 32'h600DF00D);
      chk("t6_rresp", resp, 2'b00);
      chk("t6_raddr", last_raddr, 14'h0008);

      repeat (3) @(posedge up_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
